// File: rtl/dsp_lut_iq_expand_pkg.sv
// Shared register map, pulse bit positions and register structs for the IQ LUT expander.
package dsp_lut_iq_expand_pkg;

   localparam logic [31:0] DSP_LUT_IQ_EXPAND_ID_CONST = 32'h4C55_5845;

   localparam logic [7:0] REG_CFG    = 8'h00;
   localparam logic [7:0] REG_WDATA  = 8'h04;
   localparam logic [7:0] REG_RDATA  = 8'h08;
   localparam logic [7:0] REG_PARAMS = 8'h0C;
   localparam logic [7:0] REG_ID     = 8'h10;

   localparam int WDATA_WR_BIT     = 31;
   localparam int WDATA_CLR_BIT    = 30;
   localparam int WDATA_RDNEXT_BIT = 29;

   typedef struct packed {
      logic en;
   } cfg_t;

   typedef struct packed {
      cfg_t        cfg;
      logic        wr;
      logic        clr;
      logic        rd_next;
      logic [28:0] data;
   } wo_regs_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] params;
      logic [31:0] id;
   } ro_regs_t;

endpackage

// File: rtl/intbus_interf.sv
// Internal register bus: single-cycle write strobe, read data registered one cycle after rd.
interface intbus_interf;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        wr;
   logic        rd;

   modport master (output addr, output wdata, output wr, output rd, input rdata);
   modport slave  (input addr, input wdata, input wr, input rd, output rdata);
endinterface

// File: rtl/dsp_lut_iq_expand_lane.sv
// One expansion lane: magnitude/saturation, sign and bypass delay, and the final sign/bypass mux.
module lut_expand_lane
   import dsp_lut_iq_expand_pkg::*;
#(
   parameter int CODE_WIDTH = 4,
   parameter int OUT_WIDTH  = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cap_i,
   input  logic                         adv2_i,
   input  logic                         adv3_i,
   input  logic                         en_i,
   input  logic signed [CODE_WIDTH-1:0] code_i,
   output logic        [CODE_WIDTH-2:0] mag_o,
   input  logic        [OUT_WIDTH-2:0]  entry_i,
   output logic signed [OUT_WIDTH-1:0]  out_o
);

   // The most-negative code has no positive twin; clamp it onto the last table entry.
   function automatic logic [CODE_WIDTH-2:0] sat_abs(input logic signed [CODE_WIDTH-1:0] c);
      logic [CODE_WIDTH-1:0] a;
      a = c[CODE_WIDTH-1] ? CODE_WIDTH'(-c) : CODE_WIDTH'(c);
      return a[CODE_WIDTH-1] ? {(CODE_WIDTH-1){1'b1}} : a[CODE_WIDTH-2:0];
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] apply_sign(input logic s,
                                                             input logic [OUT_WIDTH-2:0] e);
      logic signed [OUT_WIDTH-1:0] m;
      m = signed'({1'b0, e});
      return s ? -m : m;
   endfunction

   logic                        sign_p1_q, sign_p2_q;
   logic        [CODE_WIDTH-2:0] mag_p1_q, mag_d;
   logic signed [OUT_WIDTH-1:0]  byp_p1_q, byp_p2_q, byp_d;
   logic signed [OUT_WIDTH-1:0]  out_q, out_d;

   assign mag_d = sat_abs(code_i);
   assign byp_d = {code_i, {(OUT_WIDTH-CODE_WIDTH){1'b0}}};
   assign out_d = en_i ? apply_sign(sign_p2_q, entry_i) : byp_p2_q;

   // Stage 1 -> stage 2 data registers
   always_ff @(posedge clk) begin
      if (cap_i) begin
         sign_p1_q <= code_i[CODE_WIDTH-1];
         mag_p1_q  <= mag_d;
         byp_p1_q  <= byp_d;
      end
      if (adv2_i) begin
         sign_p2_q <= sign_p1_q;
         byp_p2_q  <= byp_p1_q;
      end
   end

   // Stage 3 output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else if (adv3_i) out_q <= out_d;
   end

   assign mag_o = mag_p1_q;
   assign out_o = out_q;

endmodule

// File: rtl/dsp_lut_iq_expand.sv
// IQ LUT expander top: register file, table pointers, shared two-read-port table and valid chain.
module dsp_lut_iq_expand
   import dsp_lut_iq_expand_pkg::*;
#(
   parameter logic [31:0] BASEADDR   = 32'h0,
   parameter int          CODE_WIDTH = 4,
   parameter int          OUT_WIDTH  = 12
) (
   input  logic                         clk,
   input  logic                         resetn,
   intbus_interf.slave                  bus,
   input  logic signed [CODE_WIDTH-1:0] i_in,
   input  logic signed [CODE_WIDTH-1:0] q_in,
   input  logic                         we,
   output logic signed [OUT_WIDTH-1:0]  i_out,
   output logic signed [OUT_WIDTH-1:0]  q_out,
   output logic                         valid
);

   localparam int AW    = CODE_WIDTH - 1;
   localparam int DEPTH = 2 ** AW;
   localparam int EW    = OUT_WIDTH - 1;

   logic [31:0] offset;
   logic        wr_cfg, wr_wdata;
   wo_regs_t    wo;
   ro_regs_t    ro;
   cfg_t        cfg_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, waddr;
   logic [31:0] rdata_q, rdata_d;
   logic [EW-1:0] lut_mem_q [DEPTH];
   logic [AW-1:0] mag_i_p1, mag_q_p1;
   logic [EW-1:0] entry_i_p2_q, entry_q_p2_q;
   logic          vld_p1_q, vld_p2_q, vld_p3_q;
   logic          unused_data;

   assign offset   = bus.addr - BASEADDR;
   assign wr_cfg   = bus.wr && (offset == 32'(REG_CFG));
   assign wr_wdata = bus.wr && (offset == 32'(REG_WDATA));

   always_comb begin
      wo     = '0;
      wo.cfg = cfg_q;
      if (wr_cfg) wo.cfg.en = bus.wdata[0];
      if (wr_wdata) begin
         wo.wr      = bus.wdata[WDATA_WR_BIT];
         wo.clr     = bus.wdata[WDATA_CLR_BIT];
         wo.rd_next = bus.wdata[WDATA_RDNEXT_BIT];
         wo.data    = bus.wdata[28:0];
      end
   end

   assign unused_data = ^wo.data[28:EW];

   // A clear in the same cycle as a write steers that write to entry 0.
   always_comb begin
      waddr    = wo.clr ? '0 : wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wo.clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
      if (wo.wr) wr_ptr_d = waddr + AW'(1);
      if (wo.rd_next && !wo.clr) rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_comb begin
      ro.rdata  = 32'(lut_mem_q[rd_ptr_q]);
      ro.params = {16'b0, 8'(OUT_WIDTH), 8'(CODE_WIDTH)};
      ro.id     = DSP_LUT_IQ_EXPAND_ID_CONST;
      rdata_d   = '0;
      case (offset)
         32'(REG_CFG):    rdata_d = {31'b0, cfg_q.en};
         32'(REG_RDATA):  rdata_d = ro.rdata;
         32'(REG_PARAMS): rdata_d = ro.params;
         32'(REG_ID):     rdata_d = ro.id;
         default:         rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdata_q  <= '0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
      end else begin
         cfg_q    <= wo.cfg;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (bus.rd) rdata_q <= rdata_d;
         vld_p1_q <= we;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
      end
   end

   assign bus.rdata = rdata_q;

   // Table write port and the two stage-2 read ports; reads see pre-write contents.
   always_ff @(posedge clk) begin
      if (wo.wr) lut_mem_q[waddr] <= wo.data[EW-1:0];
      if (vld_p1_q) begin
         entry_i_p2_q <= lut_mem_q[mag_i_p1];
         entry_q_p2_q <= lut_mem_q[mag_q_p1];
      end
   end

   lut_expand_lane #(.CODE_WIDTH(CODE_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane_i (
      .clk    (clk),
      .rst_n  (resetn),
      .cap_i  (we),
      .adv2_i (vld_p1_q),
      .adv3_i (vld_p2_q),
      .en_i   (cfg_q.en),
      .code_i (i_in),
      .mag_o  (mag_i_p1),
      .entry_i(entry_i_p2_q),
      .out_o  (i_out)
   );

   lut_expand_lane #(.CODE_WIDTH(CODE_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane_q (
      .clk    (clk),
      .rst_n  (resetn),
      .cap_i  (we),
      .adv2_i (vld_p1_q),
      .adv3_i (vld_p2_q),
      .en_i   (cfg_q.en),
      .code_i (q_in),
      .mag_o  (mag_q_p1),
      .entry_i(entry_q_p2_q),
      .out_o  (q_out)
   );

   assign valid = vld_p3_q;

endmodule

// File: doc/dsp_lut_iq_expand.md
Name: dsp_lut_iq_expand

Overview:
- Receive-side counterpart of the IQ LUT compressor: converts compressed signed I/Q codes back to wide linear samples.
- Each code's magnitude indexes a bus-programmed expansion table; the code's sign is then re-applied to the table entry.
- Sits after the compressed sample link (or replay memory), ahead of correlators or the FFT.
- Table load and readback go through the internal register bus, using auto-incrementing write and read pointers.

Parameters:
- BASEADDR, 0, register-file base address on intbus.
- CODE_WIDTH, 4, width of the signed compressed input code (>=2).
- OUT_WIDTH, 12, width of the signed expanded output sample (>CODE_WIDTH).

Ports:
- clk  input  1  single system clock.
- resetn  input  1  asynchronous active-low reset.
- bus  intbus_interf.slave  -  register access.
- i_in  input  CODE_WIDTH  signed I code.
- q_in  input  CODE_WIDTH  signed Q code.
- we  input  1  input sample strobe.
- i_out  output  OUT_WIDTH  signed expanded I.
- q_out  output  OUT_WIDTH  signed expanded Q.
- valid  output  1  one-cycle strobe; i_out/q_out updated.

Behaviour:
- Interface: one clock, clk; reset is resetn, asynchronous, active-low.
- Reset:
  - i_out, q_out, valid, all pipeline valids and both table pointers reset to 0; CFG.EN resets to 0.
  - Table RAM is not reset; its contents are undefined until programmed.
- Registers:
  - RW CFG: bit0 EN.
  - WO WDATA: bits[OUT_WIDTH-2:0] data; pulse bit31 wr, bit30 clr, bit29 rd_next.
  - RO RDATA: table[rd_ptr], zero-extended.
  - RO PARAMS: CODE_WIDTH[7:0], OUT_WIDTH[15:8].
- Table: DEPTH = 2**(CODE_WIDTH-1) entries, each OUT_WIDTH-1 bits unsigned. wr_ptr and rd_ptr are CODE_WIDTH-1 bits and wrap modulo DEPTH.
- Pointer updates:
  - wr pulse: table[wr_ptr] <= data; wr_ptr++.
  - rd_next pulse: rd_ptr++.
  - clr pulse: wr_ptr <= 0 and rd_ptr <= 0.
  - clr with wr in the same cycle: the write goes to address 0, then wr_ptr = 1.
  - clr with rd_next in the same cycle: rd_ptr = 0.
- Pipeline stage 1, on we:
  - Capture signs and magnitudes mag = |code|.
  - The most-negative code -2^(CODE_WIDTH-1) saturates to DEPTH-1.
  - Capture the bypass value code <<< (OUT_WIDTH-CODE_WIDTH), sign-preserving.
  - v1 <= we.
- Pipeline stage 2, on v1: synchronous read table[mag_i] and table[mag_q]; delay sign and bypass values. v2 <= v1.
- Pipeline stage 3, on v2:
  - EN=1: out = sign ? -entry : +entry.
  - EN=0: out = bypass value.
  - v3 <= v2.
- Output timing:
  - valid = v3, asserted exactly 3 cycles after each we.
  - Back-to-back we gives a continuous output stream; outputs hold their value when no valid sample is present.
- EN is sampled at stage 3, so a toggle affects the sample in stage 3 on the following cycle; no sample is dropped or duplicated.
- Table write during streaming:
  - Allowed. A write and read at the same address in the same cycle returns the old data (read-first).
  - A dual read port plus a write port is required.
- resetn asserted mid-stream: in-flight samples are discarded; no valid is emitted for samples accepted before reset.

Decomposition:
- Package dsp_lut_iq_expand_pkg:
  - DSP_LUT_IQ_EXPAND_ID_CONST.
  - CFG/WDATA WO struct.
  - RO struct.
  - Pulse bit positions.
- Sub-module lut_expand_lane, instantiated twice (I and Q): abs/saturate, sign delay, bypass shift, stage-3 mux.
- Top level holds the regs_file, pointers, the shared table RAM with two read ports, and the valid chain.

Test Plan:
All scenarios use CODE_WIDTH=4, OUT_WIDTH=12.
- Table load and readback: clr, then write 0,100,...,700 (8 writes); clr, then read RDATA with rd_next x8 -> 0,100,...,700.
- Positive expand: EN=1, i=3, q=5, single we -> valid exactly 3 cycles later; i_out=300, q_out=500.
- Negative and saturation expand: i=-3 -> -300; i=-8 -> -700; q=0 -> 0.
- Bypass: EN=0, i=-3, q=7 -> i_out=-768, q_out=1792; latency also 3 cycles.
- Streaming: 16 consecutive we with an I ramp -8..7 -> 16 consecutive valids, in order, matching the table.
- Wrap and reset: 9 writes (9th=55) -> table[0]=55, wr_ptr=1. Then assert resetn low while 3 samples are in flight -> valid stays 0, outputs 0; the first post-reset we gives valid 3 cycles later.
